// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and default widths
// for the single-port SRAM port arbiter.
package sram_arb_pkg;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } gnt_e;

  localparam int SRAM_RD_LATENCY = 1;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_RSP_DEPTH  = 2;
  localparam int DEF_CNT_WIDTH  = 2;

endpackage

// File: rtl/arb_rsp_fifo.sv
// arb_rsp_fifo: small register FIFO holding SRAM
// read data until the read consumer takes it.
module arb_rsp_fifo
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PW-1:0]         wr_q, wr_d;
  logic [PW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o     = (cnt_q == CW'(RSP_DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign pop_data_o = mem_q[rd_q];

  // Pointer and occupancy update; push+pop keeps count.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = inc(wr_q);
      if (pop_i)  rd_d = inc(rd_q);
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i && !clr_i) mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/sram_sp_port_arbiter.sv
// sram_sp_port_arbiter: round-robin sharing of one
// single-port SRAM between write and read scanners.
module sram_sp_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] addr_to_mem,
  output logic [DATA_WIDTH-1:0] data_to_mem,
  output logic                  wen_to_mem,
  output logic                  ren_to_mem,
  input  logic [DATA_WIDTH-1:0] data_from_mem
);

  localparam int L = SRAM_RD_LATENCY;

  gnt_e                 last_gnt_q, last_gnt_d;
  logic [L-1:0]         rd_pipe_q, rd_pipe_d;
  logic [CNT_WIDTH-1:0] credit_q, credit_d;
  logic                 active_q, active_d;

  logic en, can_rd, can_wr;
  logic gnt_wr, gnt_rd;
  logic push, pop, clr;
  logic fifo_full, fifo_empty;

  assign en     = clk_en & ~flush & active_q;
  assign can_rd = rd_valid &
                  (credit_q < CNT_WIDTH'(RSP_DEPTH));
  assign can_wr = wr_valid;
  assign gnt_wr = en & can_wr &
                  (~can_rd | (last_gnt_q == GNT_RD));
  assign gnt_rd = en & can_rd &
                  (~can_wr | (last_gnt_q == GNT_WR));

  assign rsp_valid = ~fifo_empty;
  assign clr       = clk_en & flush;
  assign pop       = clk_en & ~flush &
                     rsp_valid & rsp_ready;
  assign push      = clk_en & ~flush &
                     rd_pipe_q[L-1] & (~fifo_full | pop);

  // Drive the macro from whichever side won.
  always_comb begin
    wr_ready    = 1'b0;
    rd_ready    = 1'b0;
    wen_to_mem  = 1'b0;
    ren_to_mem  = 1'b0;
    addr_to_mem = '0;
    data_to_mem = '0;
    unique case (1'b1)
      gnt_wr: begin
        wr_ready    = 1'b1;
        wen_to_mem  = 1'b1;
        addr_to_mem = wr_addr;
        data_to_mem = wr_data;
      end
      gnt_rd: begin
        rd_ready    = 1'b1;
        ren_to_mem  = 1'b1;
        addr_to_mem = rd_addr;
      end
      default: ;
    endcase
  end

  // Next state: priority, read pipe, credit, active.
  always_comb begin
    last_gnt_d = last_gnt_q;
    rd_pipe_d  = rd_pipe_q;
    credit_d   = credit_q;
    active_d   = active_q;
    if (clk_en) begin
      active_d = 1'b1;
      if (flush) begin
        last_gnt_d = GNT_RD;
        rd_pipe_d  = '0;
        credit_d   = '0;
      end else begin
        rd_pipe_d = (rd_pipe_q << 1) | L'(gnt_rd);
        if (gnt_wr) last_gnt_d = GNT_WR;
        if (gnt_rd) last_gnt_d = GNT_RD;
        unique case ({gnt_rd, pop})
          2'b10:   credit_d = credit_q + CNT_WIDTH'(1);
          2'b01:   credit_d = credit_q - CNT_WIDTH'(1);
          default: ;
        endcase
      end
    end
  end

  // State registers; reset lets write win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= GNT_RD;
      rd_pipe_q  <= '0;
      credit_q   <= '0;
      active_q   <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_pipe_q  <= rd_pipe_d;
      credit_q   <= credit_d;
      active_q   <= active_d;
    end
  end

  arb_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .push_i     (push),
    .push_data_i(data_from_mem),
    .pop_i      (pop),
    .pop_data_o (rsp_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: doc/sram_sp_port_arbiter.md
Name: sram_sp_port_arbiter

Overview:
- Shares one single-port SRAM (sram_sp, 64-bit word, 9-bit address, 1-cycle read latency) between two requesters.
- The requesters are the write-scanner port and the read-scanner port of a fiber-access tile.
- Performs round-robin arbitration per cycle and read-credit flow control.
- Returns read data through a small response FIFO so the read consumer can stall without losing SRAM output.
- Sits between the scanner/buffet logic and the memory macro, and owns addr_to_mem, data_to_mem, wen_to_mem and ren_to_mem.

Parameters:
- DATA_WIDTH, 64, SRAM word width.
- ADDR_WIDTH, 9, SRAM address width.
- RSP_DEPTH, 2, read-response FIFO entries; must be >= 2.
- CNT_WIDTH, 2, width of the in-flight-plus-occupancy credit counter; must satisfy 2^CNT_WIDTH > RSP_DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  global clock enable; 0 freezes all state
- flush  in  1  synchronous clear of all state
- wr_addr  in  ADDR_WIDTH  write request address
- wr_data  in  DATA_WIDTH  write request data
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted this cycle
- rd_addr  in  ADDR_WIDTH  read request address
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted this cycle
- rsp_data  out  DATA_WIDTH  read response data (FIFO head)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- addr_to_mem  out  ADDR_WIDTH  SRAM address
- data_to_mem  out  DATA_WIDTH  SRAM write data
- wen_to_mem  out  1  SRAM write enable
- ren_to_mem  out  1  SRAM read enable
- data_from_mem  in  DATA_WIDTH  SRAM read data, valid one cycle after ren_to_mem

Behaviour:
- State registers:
  - last_gnt (0 = write, 1 = read)
  - rd_inflight (1 bit)
  - credit counter (in-flight reads plus FIFO occupancy, 0..RSP_DEPTH)
  - active (set in the first cycle after reset release)
  - response FIFO
- Reset (async, rst_n = 0):
  - all state cleared; last_gnt = 1, so write wins the first conflict.
  - wr_ready, rd_ready, wen_to_mem, ren_to_mem and rsp_valid = 0; addr_to_mem and data_to_mem = 0.
- Eligibility:
  - can_rd = rd_valid & (credit < RSP_DEPTH).
  - can_wr = wr_valid.
  - A cycle with clk_en = 0, flush = 1 or active = 0 has no grants.
- Grant (combinational, at most one per cycle):
  - Only one eligible: grant it.
  - Both eligible: grant the side not equal to last_gnt.
  - last_gnt updates only on a grant.
- On a write grant: wr_ready = 1, wen_to_mem = 1, addr_to_mem = wr_addr, data_to_mem = wr_data.
- On a read grant: rd_ready = 1, ren_to_mem = 1, addr_to_mem = rd_addr; data_to_mem holds 0.
- With no grant, all mem strobes are 0 and addr_to_mem / data_to_mem are 0.
- Read return:
  - rd_inflight is set on a read grant and cleared the next enabled cycle.
  - While rd_inflight, data_from_mem is pushed into the FIFO.
  - Push never overflows, guaranteed by credit.
- Credit:
  - +1 on read grant; -1 on FIFO pop (rsp_valid & rsp_ready).
  - Simultaneous grant and pop: unchanged.
- FIFO:
  - First-word latency: rsp_valid rises 2 cycles after the rd_ready handshake (1 SRAM + 1 FIFO register).
  - Push and pop in the same cycle with the FIFO full is legal and keeps count.
  - rsp_data holds while rsp_valid & ~rsp_ready.
- Ordering: responses return in request order. A write granted in the cycle after a read to the same address does not corrupt that read, because SRAM read data is captured at the read's latency edge.
- clk_en = 0: no grants, no strobes, all registers hold, rsp_valid keeps its registered value, pops are ignored.
- flush = 1: next edge clears the FIFO, credit, rd_inflight and last_gnt (to 1). Any read data in flight that cycle is dropped.
- Reset mid-transfer: in-flight data is discarded and no response is produced.

Decomposition:
- Package sram_arb_pkg holds:
  - typedef enum gnt_e {GNT_WR, GNT_RD}
  - localparam SRAM_RD_LATENCY = 1
  - default width constants
- Sub-module: arb_rsp_fifo, a parameterised register FIFO (DATA_WIDTH, RSP_DEPTH) with push/pop, full/empty and same-cycle push+pop when full.

Test Plan:
- Write only: wr_valid held, 4 writes to addr 0..3 with data 0xA0..0xA3. Required: wr_ready = 1 every cycle, wen_to_mem pulses 4 times, ren_to_mem = 0.
- Conflict round-robin: wr_valid and rd_valid both held for 6 cycles. Required: grant sequence W,R,W,R,W,R starting with W after reset.
- Read backpressure: 5 reads to addr 0..4 (preloaded 0x10..0x14), rsp_ready = 0. Required: only 2 reads accepted and rd_ready = 0 afterwards. After rsp_ready = 1, data returns 0x10..0x14 in order with no loss.
- Latency: one read to addr 7 (preloaded 0x77) at cycle t with rsp_ready = 1. Required: ren_to_mem at t, rsp_valid with rsp_data = 0x77 at t+2.
- clk_en / flush: clk_en = 0 for 3 cycles mid-stream, then flush with 2 responses pending. Required: clk_en = 0 produces no strobes and holds state. After flush, rsp_valid = 0, credit = 0, and the next conflict grants W.
- Async reset with a read in flight. Required: all outputs 0 immediately, and no response appears after release.
